// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end: size encodings, FSM states
// and the alignment rule applied at request accept.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    WRITE,
    RESP
  } state_t;

  // Size 3 has no legal alignment, so it is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the core's MEM stage (master) and the
// load/store front end (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: little-endian extract/extend for loads and
// lane replacement for sub-word read-modify-write stores.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    load_data  = rdata;
    merge_data = wdata;
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merge_data = rdata;
        merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merge_data = rdata;
        merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for a word-addressed data memory: one request at a time,
// sub-word stores done as read-modify-write, misaligned requests rejected.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_access_ctrl_if.slave  bus,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wr_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              bad;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign accept = bus.req_valid && bus.req_ready;
  assign bad    = is_misaligned(bus.req_size, bus.req_addr[1:0]);

  // Handshake and memory strobes decode straight from state, so reset drops
  // mem_wEn without waiting for a clock edge.
  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_err    = err_q;
  assign bus.resp_rdata  = rdata_q;
  assign mem_wEn         = (state == WRITE);
  assign mem_address     = addr_q;
  assign mem_write_data  = wr_q;

  mem_lane_unit u_lane (
    .rdata       (mem_read_data),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                        next_state = RESP;
          else if (!bus.req_we)           next_state = LOAD;
          else if (bus.req_size == SZ_WORD) next_state = WRITE;
          else                            next_state = MERGE;
        end
      end
      LOAD:    next_state = RESP;
      MERGE:   next_state = WRITE;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      wr_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        wdata_q <= bus.req_wdata;
        err_q   <= bad;
        // Loads overwrite rdata in LOAD; everything else reports zero.
        if (bad || bus.req_we) rdata_q <= '0;
        if (!bad && bus.req_we && bus.req_size == SZ_WORD) wr_q <= bus.req_wdata;
      end
      if (state == LOAD)  rdata_q <= load_data;
      if (state == MERGE) wr_q    <= merge_data;
    end
  end

endmodule
